uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Host-side write port of the UART transmitter: byte strobe in, FIFO status out.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr;
  logic [7:0]    data;
  logic          rdy;
  logic [LW-1:0] level;

  modport master (output wr, output data, input rdy, input level);
  modport slave  (input wr, input data, output rdy, output level);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a TX FIFO; frame format and baud divisor are captured
// when each frame starts so the host may reprogram them while a frame is in flight.
module uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       nbits,
  input  logic [1:0]       parity,
  input  logic             stop2,
  input  logic             cts,
  uart_tx_if.slave         bus,
  output logic             busy,
  output logic             TxD
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rdy_q, rdy_d;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] tick_q, tick_d, divM1_q, divM1_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       nbits_q, nbits_d, parity_q, parity_d;
  logic             stop2_q, stop2_d, parBit_q, parBit_d, txd_q, txd_d;

  logic             push, pop, canStart, bitEnd, parEn;
  logic [7:0]       head, mask;
  logic [2:0]       lastBit;

  assign head     = mem_q[rdPtr_q];
  assign push     = bus.wr & rdy_q;
  assign canStart = (level_q != '0) & cts;
  assign bitEnd   = (tick_q == divM1_q);
  assign parEn    = (parity_q == 2'd1) | (parity_q == 2'd2);
  assign lastBit  = {1'b0, nbits_q} + 3'd4;

  always_comb begin
    case (nbits)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    nbits_d  = nbits_q;
    parity_d = parity_q;
    stop2_d  = stop2_q;
    divM1_d  = divM1_q;
    parBit_d = parBit_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    tick_d   = (state_q == IDLE || bitEnd) ? '0 : tick_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (canStart) pop = 1'b1;
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          txd_d    = shift_q[0];
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt_q == lastBit) begin
            state_d  = parEn ? PARITY : STOP;
            txd_d    = parEn ? parBit_q : 1'b1;
            bitCnt_d = '0;
          end else begin
            shift_d  = shift_q >> 1;
            txd_d    = shift_q[1];
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d  = STOP;
          txd_d    = 1'b1;
          bitCnt_d = '0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (stop2_q && bitCnt_q == 3'd0) bitCnt_d = 3'd1;
          else if (canStart)               pop = 1'b1;
          else                             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starting a frame snapshots the head byte and the whole line configuration.
    if (pop) begin
      state_d  = START;
      txd_d    = 1'b0;
      shift_d  = head;
      nbits_d  = nbits;
      parity_d = parity;
      stop2_d  = stop2;
      divM1_d  = (divisor == '0) ? '0 : divisor - DIV_W'(1);
      parBit_d = (^(head & mask)) ^ (parity == 2'd2);
    end
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    rdy_d   = (level_d != LW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wrPtr_q] <= bus.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      rdy_q    <= 1'b1;
      state_q  <= IDLE;
      tick_q   <= '0;
      divM1_q  <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      nbits_q  <= '0;
      parity_q <= '0;
      stop2_q  <= 1'b0;
      parBit_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      rdy_q    <= rdy_d;
      state_q  <= state_d;
      tick_q   <= tick_d;
      divM1_q  <= divM1_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      nbits_q  <= nbits_d;
      parity_q <= parity_d;
      stop2_q  <= stop2_d;
      parBit_q <= parBit_d;
      txd_q    <= txd_d;
    end
  end

  assign bus.rdy   = rdy_q;
  assign bus.level = level_q;
  assign busy      = (state_q != IDLE) | (level_q != '0);
  assign TxD       = txd_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: the expected line waveform is built per frame
// from the framing rules and compared sample by sample against TxD.
module tb_uart_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divisor;
  logic [1:0]  nbits, parity;
  logic        stop2, cts;
  logic        busy, TxD;

  int checks = 0;
  int errors = 0;
  logic expQ[$];

  uart_tx_if #(.FIFO_DEPTH(16)) bus ();

  uart_tx #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .divisor(divisor), .nbits(nbits), .parity(parity),
    .stop2(stop2), .cts(cts), .bus(bus), .busy(busy), .TxD(TxD)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one queue entry per clock of line time.
  task automatic buildFrame(input logic [7:0] b, input int nb, input int par, input int s2, input int div);
    int d, ones;
    logic bits[$];
    d = (div == 0) ? 1 : div;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb + 5; i++) begin
      bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (par == 1 || par == 2) bits.push_back(logic'((ones % 2) ^ (par == 2 ? 1 : 0)));
    bits.push_back(1'b1);
    if (s2 != 0) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < d; j++) expQ.push_back(bits[k]);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.wr = 1'b1;
    bus.data = b;
    step();
    bus.wr = 1'b0;
  endtask

  task automatic compareStream(input int changeAt, input logic [15:0] newDiv, input logic [1:0] newNb);
    int n;
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      if (i == changeAt) begin
        divisor = newDiv;
        nbits = newNb;
      end
      checkOutput("txd_stream", 32'(TxD), 32'(expQ.pop_front()));
      step();
    end
  endtask

  task automatic singleFrame(input string tag, input logic [7:0] b, input int nb, input int par,
                             input int s2, input int div);
    divisor = 16'(div);
    nbits = 2'(nb);
    parity = 2'(par);
    stop2 = 1'(s2);
    buildFrame(b, nb, par, s2, div);
    applyStimulus(b);
    step();
    compareStream(-1, 16'd0, 2'd0);
    checkOutput({tag, "_idle_txd"}, 32'(TxD), 32'd1);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] bytesIn[17];
    int nb, par, s2, div;

    rst = 1'b1; cts = 1'b1; bus.wr = 1'b0; bus.data = 8'h00;
    divisor = 16'd1; nbits = 2'd3; parity = 2'd0; stop2 = 1'b0;
    step(); step();
    rst = 1'b0;
    checkOutput("rst_txd", 32'(TxD), 32'd1);
    checkOutput("rst_rdy", 32'(bus.rdy), 32'd1);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    singleFrame("f55", 8'h55, 3, 0, 0, 4);
    singleFrame("f13", 8'h13, 0, 1, 1, 2);
    singleFrame("odd00", 8'h00, 3, 2, 0, 1);
    singleFrame("oddFF", 8'hFF, 3, 2, 0, 1);
    singleFrame("div0", 8'hA6, 2, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      singleFrame("rand", 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    // Frame format and divisor changed mid-frame must not disturb the frame.
    divisor = 16'd3; nbits = 2'd3; parity = 2'd1; stop2 = 1'b0;
    buildFrame(8'hC9, 3, 1, 0, 3);
    applyStimulus(8'hC9);
    step();
    compareStream(7, 16'd7, 2'd0);
    checkOutput("midchg_busy", 32'(busy), 32'd0);

    // Fill the FIFO with cts low, overflow by one, then release back to back.
    nb = int'($urandom_range(0, 3)); par = int'($urandom_range(0, 3));
    s2 = int'($urandom_range(0, 1)); div = int'($urandom_range(1, 3));
    divisor = 16'(div); nbits = 2'(nb); parity = 2'(par); stop2 = 1'(s2);
    cts = 1'b0;
    bus.wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bytesIn[i] = 8'($urandom);
      bus.data = bytesIn[i];
      step();
    end
    bus.wr = 1'b0;
    checkOutput("full_level", 32'(bus.level), 32'd16);
    checkOutput("full_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("full_txd", 32'(TxD), 32'd1);
    for (int i = 0; i < 16; i++) buildFrame(bytesIn[i], nb, par, s2, div);
    cts = 1'b1;
    step();
    compareStream(-1, 16'd0, 2'd0);
    checkOutput("b2b_level", 32'(bus.level), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd0);

    // Reset mid-frame with bytes still queued; a write on the reset edge is ignored.
    divisor = 16'd2; nbits = 2'd3; parity = 2'd0; stop2 = 1'b0;
    cts = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'h3C + 8'(i));
    cts = 1'b1;
    step();
    checkOutput("pre_rst_start", 32'(TxD), 32'd0);
    repeat (5) step();
    checkOutput("pre_rst_level", 32'(bus.level), 32'd3);
    rst = 1'b1;
    bus.wr = 1'b1;
    bus.data = 8'h99;
    step();
    rst = 1'b0;
    bus.wr = 1'b0;
    checkOutput("mid_rst_txd", 32'(TxD), 32'd1);
    checkOutput("mid_rst_level", 32'(bus.level), 32'd0);
    checkOutput("mid_rst_rdy", 32'(bus.rdy), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      checkOutput("post_rst_quiet", 32'(TxD), 32'd1);
      step();
    end
    checkOutput("post_rst_level", 32'(bus.level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
